// File: rtl/serial_frame_rx_if.sv
// Wishbone classic slave signal bundle for serial_frame_rx.
// The master modport drives the request side; the slave modport returns data and acknowledge.
interface serial_frame_rx_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [31:0] ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Mid-bit sampling LSB-first frame deserializer with a frame FIFO drained over Wishbone classic.
// Optional FRAMES register (0xC) built only when FRX_FRAME_CNT_EN is defined.
module serial_frame_rx #(
  parameter int FRAME_W    = 10,
  parameter int BIT_CYCLES = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  serial_frame_rx_if.slave wb,
  input  logic             ena_i,
  input  logic             data_i,
  output logic             irq_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CYC_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = $clog2(FRAME_W);

  typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               ena_prev_q, ena_prev_d;
  logic [FRAME_W-1:0] frame_dat;
  logic               frame_done;

  logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d, rx_en_q, rx_en_d, flush_q, flush_d;
  logic               ack_q, ack_d, irq_q, irq_d;
  logic [31:0]        dat_q, dat_d;
  logic               wb_req, fifo_empty, fifo_full, push, pop;
  logic [1:0]         reg_sel;
  logic [31:0]        status_w;
  logic               unused_bits;

  assign frame_dat = {data_i, shreg_q[FRAME_W-1:1]};

  // START and SHIFT share the sampling path; START only marks the half-bit alignment phase.
  always_comb begin
    state_d    = state_q;
    cyc_cnt_d  = cyc_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    ena_prev_d = ena_i;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_en_q && ena_prev_q && !ena_i) begin
          state_d   = START;
          cyc_cnt_d = CYC_W'(BIT_CYCLES / 2 - 1);
          bit_idx_d = '0;
        end
      end
      START, SHIFT: begin
        if (!rx_en_q) begin
          state_d = IDLE;
        end else if (cyc_cnt_q != '0) begin
          cyc_cnt_d = cyc_cnt_q - 1'b1;
        end else if (ena_i) begin
          state_d = IDLE;
        end else begin
          state_d   = SHIFT;
          cyc_cnt_d = CYC_W'(BIT_CYCLES - 1);
          shreg_d   = frame_dat;
          if (bit_idx_q == IDX_W'(FRAME_W - 1)) begin
            bit_idx_d  = '0;
            frame_done = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_req     = wb.CYC_I && wb.STB_I && !ack_q;
  assign reg_sel    = wb.ADR_I[3:2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = wb_req && !wb.WE_I && (reg_sel == 2'd0) && !fifo_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the frame.
  assign push       = frame_done && !flush_q && (!fifo_full || pop);
  assign status_w   = {21'd0, ovf_q, fifo_full, fifo_empty, 8'(count_q)};
  assign unused_bits = ^{wb.ADR_I[31:4], wb.ADR_I[1:0], wb.DAT_I[31:3]};

`ifdef FRX_FRAME_CNT_EN
  logic [31:0] frames_q, frames_d;

  always_comb begin
    frames_d = frames_q;
    if (flush_q)   frames_d = '0;
    else if (push) frames_d = frames_q + 32'd1;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) frames_q <= '0;
    else       frames_q <= frames_d;
  end
`endif

  always_comb begin
    ack_d    = wb_req;
    dat_d    = '0;
    rx_en_d  = rx_en_q;
    flush_d  = 1'b0;
    ovf_d    = ovf_q;
    irq_d    = rx_en_q && !fifo_empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (wb_req && !wb.WE_I) begin
      case (reg_sel)
        2'd0: dat_d = fifo_empty ? 32'd0 : 32'(mem_q[rd_ptr_q]);
        2'd1: dat_d = status_w;
        2'd2: dat_d = {31'd0, rx_en_q};
`ifdef FRX_FRAME_CNT_EN
        2'd3: dat_d = frames_q;
`else
        2'd3: dat_d = '0;
`endif
      endcase
    end
    if (wb_req && wb.WE_I && (reg_sel == 2'd2)) begin
      rx_en_d = wb.DAT_I[0];
      flush_d = wb.DAT_I[1];
      if (wb.DAT_I[2]) ovf_d = 1'b0;
    end
    if (frame_done && fifo_full && !pop) ovf_d = 1'b1;
    if (flush_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem_q[wr_ptr_q] <= frame_dat;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= IDLE;
      cyc_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      ena_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rx_en_q    <= 1'b0;
      flush_q    <= 1'b0;
      ack_q      <= 1'b0;
      irq_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      ena_prev_q <= ena_prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rx_en_q    <= rx_en_d;
      flush_q    <= flush_d;
      ack_q      <= ack_d;
      irq_q      <= irq_d;
      dat_q      <= dat_d;
    end
  end

  assign wb.ACK_O = ack_q;
  assign wb.DAT_O = dat_q;
  assign irq_o    = irq_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: reads queue expected data, a negedge monitor checks each read ack.
`timescale 1ns/1ps
module tb_serial_frame_rx;
  localparam int          BC     = 4;
  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_CTRL = 32'h8;
  localparam logic [31:0] A_FRM  = 32'hC;
`ifdef FRX_FRAME_CNT_EN
  localparam bit FRM_EN = 1'b1;
`else
  localparam bit FRM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic din = 1'b0;
  logic irq;

  serial_frame_rx_if wb();

  serial_frame_rx #(.FRAME_W(10), .BIT_CYCLES(BC), .FIFO_DEPTH(8)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .wb    (wb),
    .ena_i (ena),
    .data_i(din),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always @(negedge clk) begin
    if (wb.ACK_O && !wb.WE_I) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_read_ack: got data 0x%0h, expected no ack", wb.DAT_O);
      end else begin
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (wb.DAT_O === e) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", t, wb.DAT_O, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bit got;
    got = 1'b0;
    wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = we; wb.ADR_I = adr; wb.DAT_I = dat;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb.ACK_O) got = 1'b1;
    end
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
    if (!got) begin
      n_chk++;
      $display("FAIL ack_timeout: got no ack at adr 0x%0h, expected ack within 8 cycles", adr);
    end
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    tag_q.push_back(name);
    wb_cycle(1'b0, adr, 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    wb_cycle(1'b1, adr, dat);
  endtask

  // Drives the first n bits of v, each held BC cycles, with the stream enabled.
  task automatic send_bits(input logic [9:0] v, input int n);
    ena = 1'b0;
    for (int i = 0; i < n; i++) begin
      din = v[i];
      repeat (BC) @(posedge clk);
      #1;
    end
  endtask

  task automatic stop_stream();
    ena = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish within 200us");
    $fatal(1);
  end

  initial begin
    wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
    wb.ADR_I = 32'd0; wb.DAT_I = 32'd0;

    // Reset
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_dat_o", wb.DAT_O, 32'd0);
    chk("reset_ack_o", {31'd0, wb.ACK_O}, 32'd0);
    chk("reset_irq_o", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    wb_read(A_STAT, 32'h100, "reset_status");
    wb_read(A_CTRL, 32'h0,   "reset_ctrl");

    // Single frame
    wb_write(A_CTRL, 32'h1);
    send_bits(10'h201, 10);
    stop_stream();
    chk("single_irq_set", {31'd0, irq}, 32'd1);
    wb_read(A_STAT, 32'h001, "single_status");
    wb_read(A_DATA, 32'h201, "single_data");
    wb_read(A_STAT, 32'h100, "single_status_after");
    chk("single_irq_clear", {31'd0, irq}, 32'd0);
    wb_read(A_DATA, 32'h0,   "empty_data_read");

    // Back-to-back frames
    send_bits(10'h3FF, 10);
    send_bits(10'h000, 10);
    send_bits(10'h155, 10);
    stop_stream();
    wb_read(A_STAT, 32'h003, "b2b_status");
    wb_read(A_DATA, 32'h3FF, "b2b_data0");
    wb_read(A_DATA, 32'h000, "b2b_data1");
    wb_read(A_DATA, 32'h155, "b2b_data2");

    // Abort after 6 bits, then a clean frame
    send_bits(10'h2AA, 6);
    stop_stream();
    wb_read(A_STAT, 32'h100, "abort_status");
    send_bits(10'h0F0, 10);
    stop_stream();
    wb_read(A_DATA, 32'h0F0, "abort_recover_data");

    // Overflow: nine frames into eight slots
    for (int i = 0; i < 9; i++) send_bits(10'(32'h010 + i), 10);
    stop_stream();
    wb_read(A_STAT, 32'h608, "ovf_status");
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    wb_write(A_CTRL, 32'h5);
    wb_read(A_STAT, 32'h208, "ovf_cleared_status");
    wb_read(A_FRM, FRM_EN ? 32'd13 : 32'd0, "frames_before_collide");

    // Pop acked on the same edge as a push into the full FIFO
    send_bits(10'h3C5, 9);
    din = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wb_read(A_DATA, 32'h010, "collide_data");
    stop_stream();
    wb_read(A_STAT, 32'h208, "collide_status");
    wb_read(A_FRM, FRM_EN ? 32'd14 : 32'd0, "frames_after_collide");
    for (int i = 1; i < 8; i++) wb_read(A_DATA, 32'h010 + i, "drain_data");
    wb_read(A_DATA, 32'h3C5, "drain_collide_frame");
    wb_read(A_STAT, 32'h100, "drain_status");

    // Flush
    send_bits(10'h111, 10);
    send_bits(10'h222, 10);
    stop_stream();
    wb_read(A_STAT, 32'h002, "preflush_status");
    wb_read(A_FRM, FRM_EN ? 32'd16 : 32'd0, "preflush_frames");
    wb_write(A_CTRL, 32'h3);
    wb_read(A_STAT, 32'h100, "flush_status");
    wb_read(A_FRM, 32'd0,   "flush_frames");
    wb_read(A_CTRL, 32'h1,   "flush_ctrl_readback");

    // Receiver disabled ignores the stream
    wb_write(A_CTRL, 32'h0);
    send_bits(10'h333, 10);
    stop_stream();
    wb_read(A_STAT, 32'h100, "disabled_status");
    chk("disabled_irq", {31'd0, irq}, 32'd0);

    repeat (3) @(posedge clk);
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_chk++;
      $display("FAIL missing_ack %s: got no read ack, expected one", tag_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
